// File: rtl/flappy_pipes_pkg.sv
// Shared definitions for the pipe/collision stage: geometry defaults,
// one-hot state encoding and LFSR constants.
package flappy_pipes_pkg;

    // Geometry defaults, also used by the bird FSM and the renderer
    localparam int DEF_SCREEN_H  = 600;
    localparam int DEF_SPACING   = 300;
    localparam int DEF_PIPE_W    = 60;
    localparam int DEF_GAP_H     = 150;
    localparam int DEF_GAP_MIN   = 100;
    localparam int DEF_BIRD_SIZE = 20;
    localparam int DEF_SPEED     = 2;

    // One-hot play state; each bit drives one q_* output directly
    typedef enum logic [2:0] {
        S_IDLE   = 3'b001,
        S_SCROLL = 3'b010,
        S_HIT    = 3'b100
    } state_t;

    // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/flappy_lfsr.sv
// 16-bit Galois LFSR random source for pipe gap heights. Seeded only by
// Reset so that successive games after Clear see different gaps.
module flappy_lfsr
    import flappy_pipes_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] rnd
);

    // Advance every cycle: shift right and fold in the taps when a one drops out
    always_ff @(posedge Clk) begin
        if (Reset)
            rnd <= LFSR_SEED;
        else
            rnd <= {1'b0, rnd[15:1]} ^ (rnd[0] ? LFSR_TAPS : 16'h0000);
    end

endmodule

// File: rtl/flappy_pipes.sv
// Pipe scrolling, respawn, collision and scoring stage for Flappy Bird.
// Two pipe columns scroll left on Tick, respawn two pitches to the right
// with a random gap, and a sticky Hit reports any pipe or floor collision.
module flappy_pipes
    import flappy_pipes_pkg::*;
#(
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int SPACING   = DEF_SPACING,
    parameter int PIPE_W    = DEF_PIPE_W,
    parameter int GAP_H     = DEF_GAP_H,
    parameter int GAP_MIN   = DEF_GAP_MIN,
    parameter int BIRD_SIZE = DEF_BIRD_SIZE,
    parameter int SPEED     = DEF_SPEED
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Run,
    input  logic       Clear,
    input  logic [9:0] XBird,
    input  logic [9:0] YBird,
    output logic [9:0] Pipe0X,
    output logic [9:0] Pipe1X,
    output logic [9:0] Pipe0Gap,
    output logic [9:0] Pipe1Gap,
    output logic       Hit,
    output logic [7:0] Score,
    output logic       q_Idle,
    output logic       q_Scroll,
    output logic       q_Hit
);

    // Comparisons are done 11 bits wide so sums of 10-bit values never wrap
    localparam logic [10:0] SCREEN_H11 = 11'(SCREEN_H);
    localparam logic [10:0] PIPE_W11   = 11'(PIPE_W);
    localparam logic [10:0] GAP_H11    = 11'(GAP_H);
    localparam logic [10:0] BIRD11     = 11'(BIRD_SIZE);
    localparam logic [9:0]  SPEED10    = 10'(SPEED);
    localparam logic [9:0]  WRAP_ADD   = 10'(2 * SPACING - SPEED);
    localparam logic [9:0]  X0_INIT    = 10'(2 * SPACING);
    localparam logic [9:0]  X1_INIT    = 10'(3 * SPACING);
    localparam logic [9:0]  GAP_INIT   = 10'(GAP_MIN + 128);
    localparam logic [9:0]  GAP_MIN10  = 10'(GAP_MIN);

    state_t           state;
    logic [2:0]       state_bits;
    logic [1:0][9:0]  px;
    logic [1:0][9:0]  gap;
    logic [1:0]       passed;
    logic [7:0]       score;
    logic [15:0]      rnd;

    logic [1:0]       pipe_hit;
    logic [1:0]       pass_now;
    logic [1:0]       respawn;
    logic [1:0][9:0]  next_x;
    logic [1:0][9:0]  rnd_gap;
    logic [10:0]      xb;
    logic [10:0]      yb;
    logic             floor_hit;
    logic             collide;
    logic [1:0]       inc;
    logic [8:0]       score_sum;
    logic [7:0]       score_next;

    flappy_lfsr u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .rnd   (rnd)
    );

    assign xb = {1'b0, XBird};
    assign yb = {1'b0, YBird};

    // Per-pipe collision, pass detection and next position
    for (genvar i = 0; i < 2; i++) begin : g_pipe
        logic [10:0] xi;
        logic [10:0] gi;
        logic        overlap;
        assign xi          = {1'b0, px[i]};
        assign gi          = {1'b0, gap[i]};
        assign overlap     = (xi < xb + BIRD11) && (xi + PIPE_W11 > xb);
        assign pipe_hit[i] = overlap && ((yb < gi) || (yb + BIRD11 > gi + GAP_H11));
        assign pass_now[i] = (xi + PIPE_W11 < xb);
        assign respawn[i]  = (px[i] < SPEED10);
        assign next_x[i]   = respawn[i] ? px[i] + WRAP_ADD : px[i] - SPEED10;
        assign rnd_gap[i]  = GAP_MIN10 + {2'b00, rnd[8*i +: 8]};
    end

    assign floor_hit = (yb + BIRD11 > SCREEN_H11);
    assign collide   = floor_hit || (|pipe_hit);

    // A pipe scores only on the cycle its passed flag first sets
    assign inc        = {1'b0, pass_now[0] & ~passed[0]} + {1'b0, pass_now[1] & ~passed[1]};
    assign score_sum  = {1'b0, score} + {7'b0, inc};
    assign score_next = score_sum[8] ? 8'hFF : score_sum[7:0];

    // Play FSM and per-pipe registers; Reset > Clear > collision > Tick
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= S_IDLE;
            px[0]  <= X0_INIT;
            px[1]  <= X1_INIT;
            gap[0] <= GAP_INIT;
            gap[1] <= GAP_INIT;
            passed <= 2'b00;
            score  <= 8'd0;
        end else if (Clear) begin
            state  <= S_IDLE;
            px[0]  <= X0_INIT;
            px[1]  <= X1_INIT;
            gap[0] <= rnd_gap[0];
            gap[1] <= rnd_gap[1];
            passed <= 2'b00;
            score  <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Run)
                        state <= S_SCROLL;
                end
                S_SCROLL: begin
                    score  <= score_next;
                    passed <= passed | pass_now;
                    if (collide) begin
                        state <= S_HIT;
                    end else if (Tick && Run) begin
                        for (int i = 0; i < 2; i++) begin
                            px[i] <= next_x[i];
                            if (respawn[i]) begin
                                gap[i]    <= rnd_gap[i];
                                passed[i] <= 1'b0;
                            end
                        end
                    end
                end
                S_HIT: ;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign state_bits = state;
    assign Pipe0X     = px[0];
    assign Pipe1X     = px[1];
    assign Pipe0Gap   = gap[0];
    assign Pipe1Gap   = gap[1];
    assign Score      = score;
    assign q_Idle     = state_bits[0];
    assign q_Scroll   = state_bits[1];
    assign q_Hit      = state_bits[2];
    assign Hit        = state_bits[2];

endmodule

// File: tb/tb_flappy_pipes.sv
// Bench for flappy_pipes: directed game scenarios then random play, with a
// queue-based scoreboard fed by an integer game model and a separate monitor.
module tb_flappy_pipes;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Tick = 1'b0;
    logic       Run = 1'b0;
    logic       Clear = 1'b0;
    logic [9:0] XBird = '0;
    logic [9:0] YBird = '0;
    logic [9:0] Pipe0X, Pipe1X, Pipe0Gap, Pipe1Gap;
    logic       Hit;
    logic [7:0] Score;
    logic       q_Idle, q_Scroll, q_Hit;

    flappy_pipes dut (
        .Clk(Clk), .Reset(Reset), .Tick(Tick), .Run(Run), .Clear(Clear),
        .XBird(XBird), .YBird(YBird),
        .Pipe0X(Pipe0X), .Pipe1X(Pipe1X), .Pipe0Gap(Pipe0Gap), .Pipe1Gap(Pipe1Gap),
        .Hit(Hit), .Score(Score), .q_Idle(q_Idle), .q_Scroll(q_Scroll), .q_Hit(q_Hit)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [9:0] p0x, p1x, g0, g1;
        logic       hit;
        logic [7:0] score;
        logic       qi, qs, qh;
    } snap_t;

    snap_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Game model: plain integers, mode 0=idle 1=scroll 2=hit
    int m_x[2];
    int m_gap[2];
    bit m_passed[2];
    int m_score;
    int m_mode;
    int m_lfsr;

    function automatic int lfsr_step(input int s);
        int n;
        n = s >> 1;
        if ((s & 1) != 0) n = n ^ 'hB400;
        return n;
    endfunction

    task automatic model_step();
        int cur, bx, by, inc;
        bit col, cond;
        cur = m_lfsr;
        if (Reset) begin
            m_x[0] = 600; m_x[1] = 900; m_gap[0] = 228; m_gap[1] = 228;
            m_passed[0] = 0; m_passed[1] = 0; m_score = 0; m_mode = 0;
            m_lfsr = 'hACE1;
            return;
        end
        m_lfsr = lfsr_step(m_lfsr);
        if (Clear) begin
            m_x[0] = 600; m_x[1] = 900;
            m_gap[0] = 100 + (cur & 255);
            m_gap[1] = 100 + ((cur >> 8) & 255);
            m_passed[0] = 0; m_passed[1] = 0; m_score = 0; m_mode = 0;
        end else if (m_mode == 0) begin
            if (Run) m_mode = 1;
        end else if (m_mode == 1) begin
            bx = int'(XBird); by = int'(YBird);
            col = (by + 20 > 600);
            for (int i = 0; i < 2; i++)
                if (m_x[i] < bx + 20 && m_x[i] + 60 > bx &&
                    (by < m_gap[i] || by + 20 > m_gap[i] + 150)) col = 1;
            inc = 0;
            for (int i = 0; i < 2; i++) begin
                cond = (m_x[i] + 60 < bx);
                if (cond && !m_passed[i]) inc++;
                if (cond) m_passed[i] = 1;
            end
            m_score = (m_score + inc > 255) ? 255 : m_score + inc;
            if (col) begin
                m_mode = 2;
            end else if (Tick && Run) begin
                for (int i = 0; i < 2; i++) begin
                    if (m_x[i] < 2) begin
                        m_x[i] = m_x[i] + 598;
                        m_gap[i] = 100 + ((cur >> (8 * i)) & 255);
                        m_passed[i] = 0;
                    end else begin
                        m_x[i] = m_x[i] - 2;
                    end
                end
            end
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.p0x = 10'(m_x[0]); s.p1x = 10'(m_x[1]);
        s.g0 = 10'(m_gap[0]); s.g1 = 10'(m_gap[1]);
        s.hit = (m_mode == 2); s.score = 8'(m_score);
        s.qi = (m_mode == 0); s.qs = (m_mode == 1); s.qh = (m_mode == 2);
        return s;
    endfunction

    // Drive one cycle of inputs and queue the state expected after the next edge
    task automatic drive(input bit rst, input bit clr, input bit run, input bit tck,
                         input int xb, input int yb);
        @(negedge Clk);
        Reset = rst; Clear = clr; Run = run; Tick = tck;
        XBird = 10'(xb); YBird = 10'(yb);
        model_step();
        exp_q.push_back(model_snap());
    endtask

    task automatic ticks(input int n, input bit run, input int xb, input int yb);
        for (int k = 0; k < n; k++) drive(0, 0, run, 1, xb, yb);
    endtask

    // Wait for the edge that applies the last driven inputs
    task automatic settle();
        @(posedge Clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: compare every registered output snapshot against the scoreboard
    initial begin
        snap_t e, a;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {Pipe0X, Pipe1X, Pipe0Gap, Pipe1Gap, Hit, Score, q_Idle, q_Scroll, q_Hit};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t: got p0x=%0d p1x=%0d g0=%0d g1=%0d hit=%0b score=%0d q=%0b%0b%0b expected p0x=%0d p1x=%0d g0=%0d g1=%0d hit=%0b score=%0d q=%0b%0b%0b",
                             $time, a.p0x, a.p1x, a.g0, a.g1, a.hit, a.score, a.qi, a.qs, a.qh,
                             e.p0x, e.p1x, e.g0, e.g1, e.hit, e.score, e.qi, e.qs, e.qh);
                end
            end
        end
    end

    initial begin
        int xb, yb;
        bit rst, clr, run, tck;
        // Reset values
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        settle();
        chk("reset_p0x", Pipe0X, 600);
        chk("reset_p1x", Pipe1X, 900);
        chk("reset_g0", Pipe0Gap, 228);
        chk("reset_g1", Pipe1Gap, 228);
        chk("reset_score", Score, 0);
        chk("reset_hit", Hit, 0);
        chk("reset_idle", q_Idle, 1);

        // Scroll, then freeze with Run low
        drive(0, 0, 1, 0, 700, 250);
        ticks(10, 1, 700, 250);
        settle();
        chk("scroll_p0x", Pipe0X, 580);
        chk("scroll_p1x", Pipe1X, 880);
        ticks(5, 0, 700, 250);
        settle();
        chk("freeze_p0x", Pipe0X, 580);
        chk("freeze_p1x", Pipe1X, 880);
        chk("freeze_scroll", q_Scroll, 1);

        // Wrap: 300 ticks in total brings pipe0 to 0, the next respawns it
        ticks(290, 1, 700, 250);
        settle();
        chk("wrap_p0x_zero", Pipe0X, 0);
        ticks(1, 1, 700, 250);
        settle();
        chk("wrap_p0x", Pipe0X, 598);
        chk("wrap_p1x", Pipe1X, 298);
        chk("wrap_gap_range", int'(Pipe0Gap >= 100 && Pipe0Gap <= 355), 1);

        // Pipe hit at Pipe0X=118 with the bird above the gap
        drive(1, 0, 0, 0, 100, 100);
        drive(0, 0, 1, 0, 100, 100);
        ticks(241, 1, 100, 100);
        settle();
        chk("hit_p0x", Pipe0X, 118);
        chk("hit_not_yet", Hit, 0);
        ticks(1, 1, 100, 100);
        settle();
        chk("hit_flag", Hit, 1);
        chk("hit_state", q_Hit, 1);
        chk("hit_tick_ignored", Pipe0X, 118);
        ticks(3, 1, 100, 100);
        settle();
        chk("hit_frozen", Pipe0X, 118);
        chk("hit_sticky", Hit, 1);

        // Score: bird inside the gap, pipe0 passes after tick 281
        drive(1, 0, 0, 0, 100, 240);
        drive(0, 0, 1, 0, 100, 240);
        ticks(281, 1, 100, 240);
        settle();
        chk("score_p0x", Pipe0X, 38);
        chk("score_before", Score, 0);
        drive(0, 0, 1, 0, 100, 240);
        settle();
        chk("score_after", Score, 1);
        ticks(10, 1, 100, 240);
        settle();
        chk("score_once", Score, 1);
        chk("score_nohit", Hit, 0);

        // Floor hit then Clear together with Tick
        drive(0, 0, 1, 0, 100, 581);
        settle();
        chk("floor_hit", Hit, 1);
        drive(0, 1, 1, 1, 100, 581);
        settle();
        chk("clear_idle", q_Idle, 1);
        chk("clear_hit", Hit, 0);
        chk("clear_score", Score, 0);
        chk("clear_p0x", Pipe0X, 600);
        chk("clear_p1x", Pipe1X, 900);

        // Random play against the model
        xb = 200; yb = 280;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 799) == 0);
            clr = ($urandom_range(0, 59) == 0);
            run = ($urandom_range(0, 9) != 0);
            tck = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 31) == 0) begin
                xb = $urandom_range(0, 1023);
                yb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 620) : $urandom_range(220, 360);
            end
            drive(rst, clr, run, tck, xb, yb);
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge Clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
